writeback_streamer: RTL and testbench

WRITEBACK_STREAMER -- requirements
Module: writeback_streamer

---
 rtl/writeback_streamer.sv | 142 ++++++++++++++
 tb/tb_writeback_streamer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_streamer.sv
// writeback_streamer: on each start request, reads K centroid words from memory and streams them as one AXI-Stream packet.
// Optional macro WB_HEADER_EN prepends a header beat carrying K, making the packet K+1 beats.
module writeback_streamer #(
   parameter int DATA_WIDTH = 64,
   parameter int K          = 10,
   parameter int ADDR_BITS  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_write_back_start,
   output logic                  o_write_back_done,
   output logic                  o_rd_en,
   output logic [ADDR_BITS-1:0]  o_rd_addr,
   input  logic [DATA_WIDTH-1:0] i_rd_data,
   output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
   output logic                  M_AXIS_TVALID,
   input  logic                  M_AXIS_TREADY,
   output logic                  M_AXIS_TLAST
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_READ   = 3'd1,
      S_WAIT   = 3'd2,
      S_SEND   = 3'd3,
      S_DONE   = 3'd4
`ifdef WB_HEADER_EN
      ,
      S_HEADER = 3'd5
`endif
   } state_t;

   localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(K - 1);

   state_t                  r_state;
   logic [ADDR_BITS-1:0]    r_idx;
   logic                    r_done;
   logic                    r_rd_en;
   logic [ADDR_BITS-1:0]    r_rd_addr;
   logic [DATA_WIDTH-1:0]   r_tdata;
   logic                    r_tvalid;
   logic                    r_tlast;

   logic                    w_last;
   logic [ADDR_BITS-1:0]    w_next_idx;

   assign w_last     = (r_idx == LAST_IDX);
   assign w_next_idx = r_idx + ADDR_BITS'(1);

   // Moore FSM; every output is registered and updated on the transition into its state
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_idx     <= '0;
         r_done    <= 1'b0;
         r_rd_en   <= 1'b0;
         r_rd_addr <= '0;
         r_tdata   <= '0;
         r_tvalid  <= 1'b0;
         r_tlast   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_write_back_start) begin
                  r_idx     <= '0;
`ifdef WB_HEADER_EN
                  r_state   <= S_HEADER;
                  r_tdata   <= DATA_WIDTH'(K);
                  r_tvalid  <= 1'b1;
                  r_tlast   <= 1'b0;
`else
                  r_state   <= S_READ;
                  r_rd_en   <= 1'b1;
                  r_rd_addr <= '0;
`endif
               end
            end
`ifdef WB_HEADER_EN
            S_HEADER: begin
               if (M_AXIS_TREADY) begin
                  r_state   <= S_READ;
                  r_tvalid  <= 1'b0;
                  r_rd_en   <= 1'b1;
                  r_rd_addr <= r_idx;
               end
            end
`endif
            S_READ: begin
               r_state   <= S_WAIT;
               r_rd_en   <= 1'b0;
               r_rd_addr <= '0;
            end
            // Memory data is valid throughout this cycle; capture it for the beat
            S_WAIT: begin
               r_state  <= S_SEND;
               r_tdata  <= i_rd_data;
               r_tvalid <= 1'b1;
               r_tlast  <= w_last;
            end
            S_SEND: begin
               if (M_AXIS_TREADY) begin
                  r_tvalid <= 1'b0;
                  r_tlast  <= 1'b0;
                  if (w_last) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state   <= S_READ;
                     r_idx     <= w_next_idx;
                     r_rd_en   <= 1'b1;
                     r_rd_addr <= w_next_idx;
                  end
               end
            end
            // Hold done until the scheduler drops its request so one request yields one packet
            S_DONE: begin
               if (!i_write_back_start) begin
                  r_state <= S_IDLE;
                  r_done  <= 1'b0;
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_idx     <= '0;
               r_done    <= 1'b0;
               r_rd_en   <= 1'b0;
               r_rd_addr <= '0;
               r_tvalid  <= 1'b0;
               r_tlast   <= 1'b0;
            end
         endcase
      end
   end

   assign o_write_back_done = r_done;
   assign o_rd_en           = r_rd_en;
   assign o_rd_addr         = r_rd_addr;
   assign M_AXIS_TDATA      = r_tdata;
   assign M_AXIS_TVALID     = r_tvalid;
   assign M_AXIS_TLAST      = r_tlast;

endmodule

// File: tb/tb_writeback_streamer.sv
// Self-checking bench for writeback_streamer: exact-timing directed checks plus randomized packets against a beat-queue model.
`timescale 1ns/1ps
module tb_writeback_streamer;
   localparam int DW = 64;
   localparam int KK = 10;
   localparam int AB = 4;
`ifdef WB_HEADER_EN
   localparam int H = 1;
`else
   localparam int H = 0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          done;
   logic          rd_en;
   logic [AB-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic [DW-1:0] tdata;
   logic          tvalid;
   logic          tready;
   logic          tlast;

   logic [DW-1:0] mem [0:15];
   int tests = 0;
   int fails = 0;

   writeback_streamer #(.DATA_WIDTH(DW), .K(KK), .ADDR_BITS(AB)) dut (
      .clk                (clk),
      .reset              (reset),
      .i_write_back_start (start),
      .o_write_back_done  (done),
      .o_rd_en            (rd_en),
      .o_rd_addr          (rd_addr),
      .i_rd_data          (rd_data),
      .M_AXIS_TDATA       (tdata),
      .M_AXIS_TVALID      (tvalid),
      .M_AXIS_TREADY      (tready),
      .M_AXIS_TLAST       (tlast)
   );

   always #5 clk = ~clk;

   // Memory with one-cycle read latency; garbage when not reading
   always @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_addr];
      else       rd_data <= {$urandom, $urandom};
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_done"},   done,    1'b0);
      check({tag, "_rd_en"},  rd_en,   1'b0);
      check({tag, "_rdaddr"}, rd_addr, 4'd0);
      check({tag, "_tvalid"}, tvalid,  1'b0);
      check({tag, "_tlast"},  tlast,   1'b0);
      check({tag, "_tdata"},  tdata,   64'd0);
   endtask

   task automatic fill_seq();
      for (int n = 0; n < 16; n++) mem[n] = 64'h100 + 64'(n);
   endtask

   task automatic fill_rand();
      for (int n = 0; n < 16; n++) mem[n] = {$urandom, $urandom};
   endtask

   // Randomized packet: expected beats come from a queue built from memory contents
   task automatic run_packet(input int drop_at, input bit rand_ready);
      logic [63:0] q[$];
      logic [63:0] prev_data;
      logic [63:0] e;
      bit          prev_last;
      bit          prev_stall;
      bit          finished;
      prev_stall = 1'b0;
      prev_data  = '0;
      prev_last  = 1'b0;
      finished   = 1'b0;
      q.delete();
      if (H == 1) q.push_back(64'(KK));
      for (int n = 0; n < KK; n++) q.push_back(mem[n]);
      @(negedge clk);
      start  = 1'b1;
      tready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      for (int c = 1; c < 2000 && !finished; c++) begin
         @(negedge clk);
         if (prev_stall) begin
            check($sformatf("stall_tvalid_c%0d", c), tvalid, 1'b1);
            check($sformatf("stall_tdata_c%0d", c),  tdata,  prev_data);
            check($sformatf("stall_tlast_c%0d", c),  tlast,  prev_last);
         end
         if (c == drop_at) start = 1'b0;
         tready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (tvalid && tready) begin
            if (q.size() == 0) begin
               check($sformatf("extra_beat_c%0d", c), 1'b1, 1'b0);
            end else begin
               e = q.pop_front();
               check($sformatf("beat_data_c%0d", c), tdata, e);
               check($sformatf("beat_last_c%0d", c), tlast, (q.size() == 0));
            end
         end
         prev_stall = tvalid && !tready;
         prev_data  = tdata;
         prev_last  = tlast;
         if (done) begin
            check("beats_left_at_done", q.size(), 0);
            check("no_valid_at_done", tvalid, 1'b0);
            start = 1'b0;
            @(negedge clk);
            check("done_clears", done, 1'b0);
            check("idle_tvalid", tvalid, 1'b0);
            @(negedge clk);
            check("idle_rd_en", rd_en, 1'b0);
            finished = 1'b1;
         end
      end
      if (!finished) check("packet_timeout", 1'b0, 1'b1);
      start = 1'b0;
   endtask

   initial begin
      int  idx;
      bit  ev;
      bit  hv;
      bit  re;
      bit  hold;

      reset  = 1'b1;
      start  = 1'b0;
      tready = 1'b0;
      fill_seq();
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      reset = 1'b0;
      @(negedge clk);

      // Exact timing with TREADY held high; start held 3+ cycles past done
      start  = 1'b1;
      tready = 1'b1;
      for (int c = 1; c <= 34; c++) begin
         @(negedge clk);
         idx = (c - 3 - H) / 3;
         ev  = (c >= 3 + H) && ((c - 3 - H) % 3 == 0) && (idx < KK);
         hv  = (H == 1) && (c == 1);
         check($sformatf("A_tvalid_c%0d", c), tvalid, ev | hv);
         if (ev) begin
            check($sformatf("A_tdata_c%0d", c), tdata, mem[idx]);
            check($sformatf("A_tlast_c%0d", c), tlast, (idx == KK - 1));
         end
         if (hv) begin
            check("A_hdr_tdata", tdata, 64'(KK));
            check("A_hdr_tlast", tlast, 1'b0);
         end
         re = (c >= 1 + H) && ((c - 1 - H) % 3 == 0) && ((c - 1 - H) / 3 < KK);
         check($sformatf("A_rd_en_c%0d", c), rd_en, re);
         if (re) check($sformatf("A_rd_addr_c%0d", c), rd_addr, 64'((c - 1 - H) / 3));
         check($sformatf("A_done_c%0d", c), done, (c >= 31 + H));
      end
      start = 1'b0;
      for (int c = 35; c <= 38; c++) begin
         @(negedge clk);
         check($sformatf("A_idle_done_c%0d", c), done, 1'b0);
         check($sformatf("A_idle_tvalid_c%0d", c), tvalid, 1'b0);
         check($sformatf("A_idle_rd_en_c%0d", c), rd_en, 1'b0);
      end

      // Backpressure on the first data beat
      fill_rand();
      @(negedge clk);
      start  = 1'b1;
      tready = 1'b1;
      for (int c = 1; c <= 11 + H; c++) begin
         @(negedge clk);
         hold = (c >= 3 + H) && (c <= 8 + H);
         if (hold) begin
            check($sformatf("B_hold_tvalid_c%0d", c), tvalid, 1'b1);
            check($sformatf("B_hold_tdata_c%0d", c), tdata, mem[0]);
            check($sformatf("B_hold_tlast_c%0d", c), tlast, 1'b0);
         end
         if (c == 9 + H || c == 10 + H) check($sformatf("B_gap_c%0d", c), tvalid, 1'b0);
         if (c == 11 + H) begin
            check("B_next_tvalid", tvalid, 1'b1);
            check("B_next_tdata", tdata, mem[1]);
         end
         tready = !((c >= 3 + H) && (c <= 7 + H));
      end
      tready = 1'b1;
      for (int c = 0; c < 200 && !done; c++) @(negedge clk);
      check("B_done_reached", done, 1'b1);
      start = 1'b0;
      repeat (2) @(negedge clk);

      // Reset mid-packet, then a fresh packet must start from word 0
      fill_seq();
      start  = 1'b1;
      tready = 1'b1;
      repeat (12) @(negedge clk);
      reset = 1'b1;
      start = 1'b0;
      @(negedge clk);
      check_all_zero("C_midreset");
      reset = 1'b0;
      run_packet(100000, 1'b0);

      // Start dropped at cycle 5
      fill_rand();
      run_packet(5, 1'b0);

      // Randomized backpressure and request drops
      for (int t = 0; t < 5; t++) begin
         fill_rand();
         run_packet((t % 2 == 0) ? $urandom_range(1, 20) : 100000, 1'b1);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
